id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register built as a two-entry skid buffer.
// The main entry drives ex_* directly; the skid entry absorbs one extra
// instruction when execute back-pressures, so id_ready can be a flop.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid/id_ready decode-side handshake (id_ready registered)
//   id_*              decoded payload: PC, rs1, rs2, immediate, operand
//                     select, ALU op, destination index, write enable
//   flush             drop every held instruction (branch redirect)
//   ex_valid/ex_ready execute-side handshake (ex_valid registered)
//   ex_*              registered payload from the main entry
//   stall_cnt         saturating count of back-pressured cycles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_data1,
    input  logic [XLEN-1:0]  id_data2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_immSrc,
    input  logic [3:0]       id_ALUop,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_wen,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_data1,
    output logic [XLEN-1:0]  ex_data2,
    output logic [XLEN-1:0]  ex_imm,
    output logic             ex_immSrc,
    output logic [3:0]       ex_ALUop,
    output logic [4:0]       ex_rd,
    output logic             ex_rf_wen,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned PW = 4 * XLEN + 11;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic [PW-1:0]     main_q, main_d;
    logic [PW-1:0]     skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     in_pl;
    logic              in_fire;
    logic              out_fire;

    assign in_pl = {id_pc, id_data1, id_data2, id_imm, id_immSrc, id_ALUop, id_rd, id_rf_wen};
    assign {ex_pc, ex_data1, ex_data2, ex_imm, ex_immSrc, ex_ALUop, ex_rd, ex_rf_wen} = main_q;

    assign ex_valid  = valid_q;
    assign id_ready  = ready_q;
    assign stall_cnt = cnt_q;

    assign in_fire  = id_valid & ready_q;
    assign out_fire = valid_q & ex_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Accepted input in this cycle is dropped; no payload load.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        main_d  = in_pl;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = in_pl;
                    end else if (in_fire) begin
                        state_d = StTwo;
                        skid_d  = in_pl;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Handshake outputs are registered from the next state.
        valid_d = (state_d != StEmpty);
        ready_d = (state_d != StTwo);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !ex_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a queue-based model of the two-entry stage is
// compared every cycle, plus hand-computed checks for the key scenarios.
module tb_id_ex_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] imm;
        logic        isrc;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, flush, ex_ready;
    logic [63:0] id_pc, id_data1, id_data2, id_imm;
    logic        id_immSrc, id_rf_wen;
    logic [3:0]  id_ALUop;
    logic [4:0]  id_rd;

    logic        id_ready, ex_valid, ex_immSrc, ex_rf_wen;
    logic [63:0] ex_pc, ex_data1, ex_data2, ex_imm;
    logic [3:0]  ex_ALUop;
    logic [4:0]  ex_rd;
    logic [31:0] stall_cnt;

    logic        id_ready4, ex_valid4, ex_immSrc4, ex_rf_wen4;
    logic [63:0] ex_pc4, ex_data14, ex_data24, ex_imm4;
    logic [3:0]  ex_ALUop4;
    logic [4:0]  ex_rd4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .id_immSrc(id_immSrc), .id_ALUop(id_ALUop), .id_rd(id_rd), .id_rf_wen(id_rf_wen),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
        .ex_immSrc(ex_immSrc), .ex_ALUop(ex_ALUop), .ex_rd(ex_rd), .ex_rf_wen(ex_rf_wen),
        .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.XLEN(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready4),
        .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
        .id_immSrc(id_immSrc), .id_ALUop(id_ALUop), .id_rd(id_rd), .id_rf_wen(id_rf_wen),
        .flush(flush), .ex_valid(ex_valid4), .ex_ready(ex_ready),
        .ex_pc(ex_pc4), .ex_data1(ex_data14), .ex_data2(ex_data24), .ex_imm(ex_imm4),
        .ex_immSrc(ex_immSrc4), .ex_ALUop(ex_ALUop4), .ex_rd(ex_rd4), .ex_rf_wen(ex_rf_wen4),
        .stall_cnt(stall_cnt4)
    );

    pl_t in_pl, dut_pl, dut4_pl;
    assign in_pl   = {id_pc, id_data1, id_data2, id_imm, id_immSrc, id_ALUop, id_rd, id_rf_wen};
    assign dut_pl  = {ex_pc, ex_data1, ex_data2, ex_imm, ex_immSrc, ex_ALUop, ex_rd, ex_rf_wen};
    assign dut4_pl = {ex_pc4, ex_data14, ex_data24, ex_imm4, ex_immSrc4, ex_ALUop4, ex_rd4,
                      ex_rf_wen4};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_pl(input string name, input pl_t got, input pl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: in-flight instructions as a FIFO of at most two; head is on ex_*.
    pl_t         m_q[$];
    pl_t         m_last = '0;
    logic [31:0] m_cnt  = '0;
    logic [3:0]  m_cnt4 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_last = '0;
            m_cnt  = '0;
            m_cnt4 = '0;
        end else begin
            bit in_f, out_f;
            in_f  = id_valid && (m_q.size() < 2);
            out_f = (m_q.size() > 0) && ex_ready;
            if ((m_q.size() > 0) && !ex_ready) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
            end
            if (flush) begin
                m_q.delete();
            end else begin
                if (out_f) void'(m_q.pop_front());
                if (in_f) m_q.push_back(in_pl);
            end
            if (m_q.size() > 0) m_last = m_q[0];
        end
    end

    always @(negedge clk) begin
        chk("m_ex_valid", {63'b0, ex_valid}, {63'b0, m_q.size() > 0});
        chk("m_id_ready", {63'b0, id_ready}, {63'b0, m_q.size() < 2});
        chk("m_stall_cnt", {32'b0, stall_cnt}, {32'b0, m_cnt});
        chk_pl("m_payload", dut_pl, m_last);
        chk("m4_ex_valid", {63'b0, ex_valid4}, {63'b0, m_q.size() > 0});
        chk("m4_id_ready", {63'b0, id_ready4}, {63'b0, m_q.size() < 2});
        chk("m4_stall_cnt", {60'b0, stall_cnt4}, {60'b0, m_cnt4});
        chk_pl("m4_payload", dut4_pl, m_last);
    end

    task automatic set_pl(input logic [63:0] t);
        id_pc     = t << 2;
        id_data1  = t;
        id_data2  = ~t;
        id_imm    = -t;
        id_immSrc = t[0];
        id_ALUop  = t[3:0];
        id_rd     = t[4:0];
        id_rf_wen = t[1];
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] s0;
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        set_pl(64'h0);
        repeat (2) cyc();
        chk("rst_ex_valid", {63'b0, ex_valid}, 64'd0);
        chk("rst_id_ready", {63'b0, id_ready}, 64'd1);
        chk("rst_stall", {32'b0, stall_cnt}, 64'd0);
        chk("rst_data1", ex_data1, 64'd0);
        rst_n = 1'b1;
        cyc();

        // Single instruction, one-cycle latency.
        set_pl(64'h0); id_data1 = 64'h5; id_ALUop = 4'h1;
        id_valid = 1'b1; ex_ready = 1'b1;
        cyc();
        id_valid = 1'b0;
        chk("single_valid", {63'b0, ex_valid}, 64'd1);
        chk("single_data1", ex_data1, 64'h5);
        chk("single_aluop", {60'b0, ex_ALUop}, 64'h1);
        cyc();
        chk("single_gone", {63'b0, ex_valid}, 64'd0);

        // Back-to-back stream at full rate.
        for (int i = 0; i < 10; i++) begin
            set_pl(64'd100 + 64'(i)); id_valid = 1'b1;
            cyc();
            chk("stream_valid", {63'b0, ex_valid}, 64'd1);
            chk("stream_data1", ex_data1, 64'd100 + 64'(i));
            chk("stream_ready", {63'b0, id_ready}, 64'd1);
        end
        id_valid = 1'b0;
        cyc();
        chk("stream_end", {63'b0, ex_valid}, 64'd0);

        // Back-pressure fills both entries; A stays stable.
        ex_ready = 1'b0;
        set_pl(64'd200); id_valid = 1'b1; cyc();
        set_pl(64'd201); cyc();
        chk("bp_full", {63'b0, id_ready}, 64'd0);
        chk("bp_head", ex_data1, 64'd200);
        s0 = stall_cnt;
        set_pl(64'd202); cyc();
        chk("bp_stable", ex_data1, 64'd200);
        chk("bp_stall1", {32'b0, stall_cnt}, {32'b0, s0 + 32'd1});
        cyc();
        chk("bp_stall2", {32'b0, stall_cnt}, {32'b0, s0 + 32'd2});
        id_valid = 1'b0; ex_ready = 1'b1;
        cyc();
        chk("bp_second", ex_data1, 64'd201);
        chk("bp_second_v", {63'b0, ex_valid}, 64'd1);
        chk("bp_ready", {63'b0, id_ready}, 64'd1);
        cyc();
        chk("bp_drained", {63'b0, ex_valid}, 64'd0);

        // Flush while full, with a new instruction offered.
        ex_ready = 1'b0;
        set_pl(64'd300); id_valid = 1'b1; cyc();
        set_pl(64'd301); cyc();
        set_pl(64'd302); flush = 1'b1; cyc();
        flush = 1'b0; id_valid = 1'b0;
        chk("flush_valid", {63'b0, ex_valid}, 64'd0);
        chk("flush_ready", {63'b0, id_ready}, 64'd1);
        chk("flush_hold", ex_data1, 64'd300);
        ex_ready = 1'b1; cyc();
        chk("flush_noC", {63'b0, ex_valid}, 64'd0);

        // Saturation of the narrow counter.
        ex_ready = 1'b0;
        set_pl(64'd400); id_valid = 1'b1; cyc();
        id_valid = 1'b0;
        repeat (20) cyc();
        chk("sat_cnt4", {60'b0, stall_cnt4}, 64'd15);
        chk("sat_valid", {63'b0, ex_valid4}, 64'd1);
        ex_ready = 1'b1; cyc();

        // Mixed traffic pattern.
        for (int i = 0; i < 30; i++) begin
            set_pl(64'd500 + 64'(i));
            id_valid = (i % 3) != 2;
            ex_ready = (i % 4) != 0;
            cyc();
        end
        id_valid = 1'b0; ex_ready = 1'b1;
        repeat (3) cyc();

        // Asynchronous reset while full.
        ex_ready = 1'b0;
        set_pl(64'd600); id_valid = 1'b1; cyc();
        set_pl(64'd601); cyc();
        id_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'b0, ex_valid}, 64'd0);
        chk("arst_ready", {63'b0, id_ready}, 64'd1);
        chk("arst_stall", {32'b0, stall_cnt}, 64'd0);
        chk("arst_stall4", {60'b0, stall_cnt4}, 64'd0);
        chk("arst_data1", ex_data1, 64'd0);
        cyc();
        rst_n = 1'b1;
        set_pl(64'd700); id_valid = 1'b1; ex_ready = 1'b1;
        cyc();
        id_valid = 1'b0;
        chk("post_rst_valid", {63'b0, ex_valid}, 64'd1);
        chk("post_rst_data1", ex_data1, 64'd700);
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
